// File: rtl/alu_operand_arbiter.sv
// alu_operand_arbiter
// Shares one ALU between the core pipeline and the XMM (Q15) unit.
// - Each cycle it picks one requester. The core wins by default. XMM wins once
//   it has been denied STARVE_LIMIT cycles in a row.
// - The winner's operand selects and opcode are registered onto the ALU.
// - An owner tag follows each op so the result strobe returns to the right unit.
// Optional build macro: ALU_ARB_PERF_EN enables the saturating perf counters.
// When the macro is undefined, the perf outputs are tied to zero.
module alu_operand_arbiter #(
  parameter int ALU_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic [2:0]  core_a_src,
  input  logic [2:0]  core_b_src,
  input  logic [3:0]  core_op,
  output logic        core_gnt,
  output logic        core_rsp_valid,
  input  logic        xmm_req,
  input  logic [2:0]  xmm_a_src,
  input  logic [2:0]  xmm_b_src,
  input  logic [3:0]  xmm_op,
  output logic        xmm_gnt,
  output logic        xmm_rsp_valid,
  output logic        alu_issue,
  output logic [2:0]  alu_a_src,
  output logic [2:0]  alu_b_src,
  output logic [3:0]  alu_op,
  output logic        alu_owner,
  output logic        illegal_src,
  output logic [15:0] perf_core_cnt,
  output logic [15:0] perf_xmm_cnt,
  output logic [15:0] perf_stall_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Select code 111 is not a real mux input. It is replaced by the zero source.
  function automatic logic [2:0] sanitize_src(input logic [2:0] src);
    return (src == 3'b111) ? 3'b000 : src;
  endfunction

  function automatic logic is_illegal(input logic [2:0] a, input logic [2:0] b);
    return (a == 3'b111) || (b == 3'b111);
  endfunction

  logic [3:0] xmm_wait;
  logic       xmm_starved;
  logic       vld_p0;
  logic [2:0] a_src_p0;
  logic [2:0] b_src_p0;
  logic [3:0] op_p0;
  logic       owner_p0;
  logic       illegal_q;
  logic [ALU_LATENCY-1:0] rsp_vld_p;
  logic [ALU_LATENCY-1:0] rsp_own_p;

  // Combinational arbitration: the core wins unless XMM has hit its starvation limit.
  always_comb begin
    xmm_starved = xmm_req && (xmm_wait == LIMIT);
    core_gnt    = core_req && !xmm_starved;
    xmm_gnt     = xmm_req && !core_gnt;
  end

  // Count consecutive denied XMM cycles (saturating).
  // The count clears on an XMM grant or whenever XMM stops requesting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xmm_wait <= '0;
    end else if (!xmm_req || xmm_gnt) begin
      xmm_wait <= '0;
    end else if (xmm_wait != LIMIT) begin
      xmm_wait <= xmm_wait + 4'd1;
    end
  end

  // ---- stage p0: issue register driving the ALU input muxes ----
  // Register the winner's fields. The fields hold their values when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0    <= 1'b0;
      a_src_p0  <= '0;
      b_src_p0  <= '0;
      op_p0     <= '0;
      owner_p0  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      vld_p0 <= core_gnt || xmm_gnt;
      if (core_gnt) begin
        a_src_p0 <= sanitize_src(core_a_src);
        b_src_p0 <= sanitize_src(core_b_src);
        op_p0    <= core_op;
        owner_p0 <= 1'b0;
        if (is_illegal(core_a_src, core_b_src)) illegal_q <= 1'b1;
      end else if (xmm_gnt) begin
        a_src_p0 <= sanitize_src(xmm_a_src);
        b_src_p0 <= sanitize_src(xmm_b_src);
        op_p0    <= xmm_op;
        owner_p0 <= 1'b1;
        if (is_illegal(xmm_a_src, xmm_b_src)) illegal_q <= 1'b1;
      end
    end
  end

  assign alu_issue   = vld_p0;
  assign alu_a_src   = a_src_p0;
  assign alu_b_src   = b_src_p0;
  assign alu_op      = op_p0;
  assign alu_owner   = owner_p0;
  assign illegal_src = illegal_q;

  // ---- stages p1..pN: owner tag tracks the op through the ALU latency ----
  // Shift the valid/owner tag one stage per cycle. Reset drops any responses in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_p <= '0;
      rsp_own_p <= '0;
    end else begin
      rsp_vld_p[0] <= vld_p0;
      rsp_own_p[0] <= owner_p0;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        rsp_vld_p[i] <= rsp_vld_p[i-1];
        rsp_own_p[i] <= rsp_own_p[i-1];
      end
    end
  end

  assign core_rsp_valid = rsp_vld_p[ALU_LATENCY-1] && !rsp_own_p[ALU_LATENCY-1];
  assign xmm_rsp_valid  = rsp_vld_p[ALU_LATENCY-1] &&  rsp_own_p[ALU_LATENCY-1];

`ifdef ALU_ARB_PERF_EN
  logic [15:0] core_cnt;
  logic [15:0] xmm_cnt;
  logic [15:0] stall_cnt;
  logic        stall;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A stall is any cycle in which at least one request was left unserved.
  assign stall = (core_req && !core_gnt) || (xmm_req && !xmm_gnt);

  // Saturating event counters for grants and stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_cnt  <= '0;
      xmm_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (core_gnt) core_cnt  <= sat_inc(core_cnt);
      if (xmm_gnt)  xmm_cnt   <= sat_inc(xmm_cnt);
      if (stall)    stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign perf_core_cnt  = core_cnt;
  assign perf_xmm_cnt   = xmm_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_core_cnt  = 16'h0;
  assign perf_xmm_cnt   = 16'h0;
  assign perf_stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Testbench for alu_operand_arbiter. Uses ALU_LATENCY=3 and STARVE_LIMIT=4.
// Stimulus is a table of per-cycle vectors with hand-derived expected values.
// Hand-written sequences cover reset behaviour, including reset during flight.
module tb_alu_operand_arbiter;
  localparam int LAT = 3;
  localparam int NV  = 25;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req, xmm_req;
  logic [2:0]  core_a_src, core_b_src, xmm_a_src, xmm_b_src;
  logic [3:0]  core_op, xmm_op;
  logic        core_gnt, xmm_gnt, core_rsp_valid, xmm_rsp_valid;
  logic        alu_issue, alu_owner, illegal_src;
  logic [2:0]  alu_a_src, alu_b_src;
  logic [3:0]  alu_op;
  logic [15:0] perf_core_cnt, perf_xmm_cnt, perf_stall_cnt;

  int checks   = 0;
  int failures = 0;

  alu_operand_arbiter #(.ALU_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_a_src(core_a_src), .core_b_src(core_b_src), .core_op(core_op),
    .core_gnt(core_gnt), .core_rsp_valid(core_rsp_valid),
    .xmm_req(xmm_req), .xmm_a_src(xmm_a_src), .xmm_b_src(xmm_b_src), .xmm_op(xmm_op),
    .xmm_gnt(xmm_gnt), .xmm_rsp_valid(xmm_rsp_valid),
    .alu_issue(alu_issue), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_op(alu_op),
    .alu_owner(alu_owner), .illegal_src(illegal_src),
    .perf_core_cnt(perf_core_cnt), .perf_xmm_cnt(perf_xmm_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cr; int ca; int cb; int cop;
    int xr; int xa; int xb; int xop;
    int gc; int gx;
    int iss; int a; int b; int op; int own; int ill;
  } vec_t;

  vec_t tbl[NV];
  int   h_iss[NV];
  int   h_own[NV];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " alu_issue"}, int'(alu_issue), 0);
    check({tag, " alu_a_src"}, int'(alu_a_src), 0);
    check({tag, " alu_b_src"}, int'(alu_b_src), 0);
    check({tag, " alu_op"}, int'(alu_op), 0);
    check({tag, " alu_owner"}, int'(alu_owner), 0);
    check({tag, " illegal_src"}, int'(illegal_src), 0);
    check({tag, " core_rsp"}, int'(core_rsp_valid), 0);
    check({tag, " xmm_rsp"}, int'(xmm_rsp_valid), 0);
    check({tag, " gnts"}, int'({core_gnt, xmm_gnt}), 0);
    check({tag, " perf_core"}, int'(perf_core_cnt), 0);
    check({tag, " perf_xmm"}, int'(perf_xmm_cnt), 0);
    check({tag, " perf_stall"}, int'(perf_stall_cnt), 0);
  endtask

  initial begin
    //          cr ca cb cop xr xa xb xop gc gx iss a  b  op own ill
    tbl[0]  = '{1, 3, 4, 2,  0, 0, 0, 0,  1, 0, 1,  3, 4, 2,  0, 0};
    tbl[1]  = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  3, 4, 2,  0, 0};
    tbl[2]  = '{0, 0, 0, 0,  1, 7, 2, 5,  0, 1, 1,  0, 2, 5,  1, 1};
    tbl[3]  = '{1, 1, 2, 1,  1, 5, 6, 7,  1, 0, 1,  1, 2, 1,  0, 1};
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = tbl[3];
    tbl[7]  = '{1, 1, 2, 1,  1, 5, 6, 7,  0, 1, 1,  5, 6, 7,  1, 1};
    tbl[8]  = tbl[3];
    tbl[9]  = '{0, 1, 2, 1,  1, 5, 6, 7,  0, 1, 1,  5, 6, 7,  1, 1};
    tbl[10] = '{1, 6, 7, 15, 0, 0, 0, 0,  1, 0, 1,  6, 0, 15, 0, 1};
    tbl[11] = '{0, 0, 0, 0,  1, 0, 1, 3,  0, 1, 1,  0, 1, 3,  1, 1};
    tbl[12] = '{1, 2, 3, 4,  0, 0, 0, 0,  1, 0, 1,  2, 3, 4,  0, 1};
    tbl[13] = '{0, 0, 0, 0,  1, 4, 5, 8,  0, 1, 1,  4, 5, 8,  1, 1};
    tbl[14] = '{1, 1, 1, 9,  1, 2, 2, 10, 1, 0, 1,  1, 1, 9,  0, 1};
    tbl[15] = tbl[14];
    tbl[16] = '{1, 1, 1, 9,  0, 0, 0, 0,  1, 0, 1,  1, 1, 9,  0, 1};
    tbl[17] = tbl[14];
    tbl[18] = tbl[14];
    tbl[19] = tbl[14];
    tbl[20] = tbl[14];
    tbl[21] = '{1, 1, 1, 9,  1, 2, 2, 10, 0, 1, 1,  2, 2, 10, 1, 1};
    tbl[22] = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  2, 2, 10, 1, 1};
    tbl[23] = tbl[22];
    tbl[24] = tbl[22];

    reset_n = 1'b0;
    core_req = 1'b0; core_a_src = '0; core_b_src = '0; core_op = '0;
    xmm_req  = 1'b0; xmm_a_src  = '0; xmm_b_src  = '0; xmm_op  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      core_req   = tbl[i].cr[0];
      core_a_src = 3'(tbl[i].ca);
      core_b_src = 3'(tbl[i].cb);
      core_op    = 4'(tbl[i].cop);
      xmm_req    = tbl[i].xr[0];
      xmm_a_src  = 3'(tbl[i].xa);
      xmm_b_src  = 3'(tbl[i].xb);
      xmm_op     = 4'(tbl[i].xop);
      #1;
      check($sformatf("r%0d core_gnt", i), int'(core_gnt), tbl[i].gc);
      check($sformatf("r%0d xmm_gnt", i), int'(xmm_gnt), tbl[i].gx);
      @(posedge clk);
      #1;
      check($sformatf("r%0d alu_issue", i), int'(alu_issue), tbl[i].iss);
      check($sformatf("r%0d alu_a_src", i), int'(alu_a_src), tbl[i].a);
      check($sformatf("r%0d alu_b_src", i), int'(alu_b_src), tbl[i].b);
      check($sformatf("r%0d alu_op", i), int'(alu_op), tbl[i].op);
      check($sformatf("r%0d alu_owner", i), int'(alu_owner), tbl[i].own);
      check($sformatf("r%0d illegal_src", i), int'(illegal_src), tbl[i].ill);
      h_iss[i] = tbl[i].iss;
      h_own[i] = tbl[i].own;
      if (i >= LAT) begin
        check($sformatf("r%0d core_rsp", i), int'(core_rsp_valid),
              (h_iss[i-LAT] == 1 && h_own[i-LAT] == 0) ? 1 : 0);
        check($sformatf("r%0d xmm_rsp", i), int'(xmm_rsp_valid),
              (h_iss[i-LAT] == 1 && h_own[i-LAT] == 1) ? 1 : 0);
      end else begin
        check($sformatf("r%0d core_rsp", i), int'(core_rsp_valid), 0);
        check($sformatf("r%0d xmm_rsp", i), int'(xmm_rsp_valid), 0);
      end
    end

`ifdef ALU_ARB_PERF_EN
    check("perf_core_cnt", int'(perf_core_cnt), 15);
    check("perf_xmm_cnt", int'(perf_xmm_cnt), 6);
    check("perf_stall_cnt", int'(perf_stall_cnt), 13);
`else
    check("perf_core_cnt", int'(perf_core_cnt), 0);
    check("perf_xmm_cnt", int'(perf_xmm_cnt), 0);
    check("perf_stall_cnt", int'(perf_stall_cnt), 0);
`endif

    // Reset asserted one cycle after an issue, while the response is still in flight.
    core_req = 1'b1; core_a_src = 3'b011; core_b_src = 3'b011; core_op = 4'h1;
    @(posedge clk);
    #1;
    check("flight issue", int'(alu_issue), 1);
    core_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset c%0d rsp", k), int'({core_rsp_valid, xmm_rsp_valid}), 0);
      check($sformatf("post-reset c%0d issue", k), int'(alu_issue), 0);
    end
    check("post-reset illegal_src", int'(illegal_src), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
